// File: rtl/mycpu_mem_pkg.sv
// Shared memory-pipeline definitions: size codes common to the load and
// store formatters, mode-bit positions and the load write-back FSM encoding.
package mycpu_mem_pkg;

  // Size field mode[3:1]
  localparam logic [2:0] SZ_B   = 3'b000;
  localparam logic [2:0] SZ_H   = 3'b001;
  localparam logic [2:0] SZ_W   = 3'b010;
  localparam logic [2:0] SZ_LWL = 3'b011;
  localparam logic [2:0] SZ_LWR = 3'b100;

  // Mode bit positions
  localparam int LOAD_BIT  = 5;
  localparam int STORE_BIT = 4;
  localparam int SEXT_BIT  = 0;

  // Load write-back FSM
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_DATA  = 2'd1,
    ST_HELD  = 2'd2
  } loadState_t;

  // Halfword needs 2-byte alignment, word needs 4-byte alignment.
  function automatic logic isMisaligned(input logic [2:0] size, input logic [1:0] off);
    isMisaligned = ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load formatter: picks the addressed byte/half/word out of
// the SRAM read word and extends it, or merges it with rt for LWL/LWR.
module load_extract
  import mycpu_mem_pkg::*;
(
  input  logic [3:0]  mode,
  input  logic [1:0]  addrLow2,
  input  logic [31:0] rtOld,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic        sext;

  assign sext = mode[SEXT_BIT];

  // Select the addressed byte and halfword (little-endian lanes)
  always_comb begin
    byteSel = rdata[7:0];
    case (addrLow2)
      2'd0: byteSel = rdata[7:0];
      2'd1: byteSel = rdata[15:8];
      2'd2: byteSel = rdata[23:16];
      2'd3: byteSel = rdata[31:24];
      default: byteSel = rdata[7:0];
    endcase
    halfSel = addrLow2[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend or merge by size code; unknown sizes yield zero
  always_comb begin
    data = '0;
    case (mode[3:1])
      SZ_B: data = {{24{sext & byteSel[7]}}, byteSel};
      SZ_H: data = {{16{sext & halfSel[15]}}, halfSel};
      SZ_W: data = rdata;
      SZ_LWL: begin
        case (addrLow2)
          2'd0: data = {rdata[7:0],  rtOld[23:0]};
          2'd1: data = {rdata[15:0], rtOld[15:0]};
          2'd2: data = {rdata[23:0], rtOld[7:0]};
          2'd3: data = rdata;
          default: data = '0;
        endcase
      end
      SZ_LWR: begin
        case (addrLow2)
          2'd0: data = rdata;
          2'd1: data = {rtOld[31:24], rdata[31:8]};
          2'd2: data = {rtOld[31:16], rdata[31:16]};
          2'd3: data = {rtOld[31:8],  rdata[31:24]};
          default: data = '0;
        endcase
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_align_wb.sv
// MEM->WB load aligner. Accepts a load in MEM, formats the SRAM word that
// arrives one cycle later and presents it to WB with a valid/ready handshake.
// Optional macro LOAD_ADDR_EXC_EN adds the adel (misaligned load) output.
//
// Handshake: a request transfers when in_valid & in_ready & mode[5]; a
// result transfers when out_valid & out_ready. in_ready is high only when
// the single result slot is empty or is being drained this cycle, so a
// result is never overwritten before WB takes it.
module load_align_wb
  import mycpu_mem_pkg::*;
#(
  parameter int DEST_W = 5,
  parameter int RT_W   = 32   // must be 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        mode,
  input  logic [1:0]        addr_low2,
  input  logic [RT_W-1:0]   rt_old,
  input  logic [DEST_W-1:0] dest,
  input  logic [RT_W-1:0]   sram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RT_W-1:0]   wb_data,
  output logic [DEST_W-1:0] wb_dest,
  output logic              load_pending,
  output logic [DEST_W-1:0] pending_dest,
`ifdef LOAD_ADDR_EXC_EN
  output logic              adel,
`endif
  output logic [1:0]        stateDbg
);

  loadState_t        state, stateNext;
  logic              accept;
  logic              holdLoad;
  logic [3:0]        modeReg;
  logic [1:0]        addrReg;
  logic [RT_W-1:0]   rtReg;
  logic [DEST_W-1:0] destReg;
  logic [RT_W-1:0]   holdData;
  logic [RT_W-1:0]   extData;
  logic [RT_W-1:0]   fmtData;
  logic              adelNow;
  logic              unusedStoreBit;

  // Store bit has no meaning on the load path
  assign unusedStoreBit = mode[STORE_BIT];

  assign in_ready = (state == ST_EMPTY) | out_ready;
  assign accept   = in_valid & in_ready & mode[LOAD_BIT];
  assign stateDbg = state;

  load_extract uExtract (
    .mode     (modeReg),
    .addrLow2 (addrReg),
    .rtOld    (rtReg),
    .rdata    (sram_rdata),
    .data     (extData)
  );

  assign adelNow = isMisaligned(modeReg[3:1], addrReg);

`ifdef LOAD_ADDR_EXC_EN
  assign fmtData = adelNow ? '0 : extData;
  assign adel    = (state != ST_EMPTY) & adelNow;
`else
  assign fmtData = extData;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_EMPTY;
    else         state <= stateNext;
  end

  // Next-state logic and hold-register capture enable
  always_comb begin
    stateNext = state;
    holdLoad  = 1'b0;
    case (state)
      ST_EMPTY: if (accept) stateNext = ST_DATA;
      ST_DATA: begin
        if (out_ready) stateNext = accept ? ST_DATA : ST_EMPTY;
        else begin
          stateNext = ST_HELD;
          holdLoad  = 1'b1;
        end
      end
      ST_HELD: if (out_ready) stateNext = accept ? ST_DATA : ST_EMPTY;
      default: stateNext = ST_EMPTY;
    endcase
  end

  // Request side-band registers, captured on acceptance
  always_ff @(posedge clk) begin
    if (!resetn) begin
      modeReg <= '0;
      addrReg <= '0;
      rtReg   <= '0;
      destReg <= '0;
    end else if (accept) begin
      modeReg <= mode[3:0];
      addrReg <= addr_low2;
      rtReg   <= rt_old;
      destReg <= dest;
    end
  end

  // Hold register keeps the result while WB stalls (SRAM data goes stale)
  always_ff @(posedge clk) begin
    if (!resetn)       holdData <= '0;
    else if (holdLoad) holdData <= fmtData;
  end

  // Output muxing: live formatter in DATA, hold register in HELD
  always_comb begin
    out_valid    = (state != ST_EMPTY);
    wb_data      = '0;
    if (state == ST_DATA)      wb_data = fmtData;
    else if (state == ST_HELD) wb_data = holdData;
    wb_dest      = out_valid ? destReg : '0;
    load_pending = out_valid;
    pending_dest = out_valid ? destReg : '0;
  end

endmodule

// File: tb/tb_load_align_wb.sv
// Bench for load_align_wb: directed vector table, hand-written multi-cycle
// sequences, and a randomized stream scored against a reference model.
module tb_load_align_wb;
  localparam int DW = 5;

  logic          clk, resetn;
  logic          in_valid, in_ready;
  logic [5:0]    mode;
  logic [1:0]    addr_low2;
  logic [31:0]   rt_old, sram_rdata, wb_data;
  logic [DW-1:0] dest, wb_dest, pending_dest;
  logic          out_valid, out_ready, load_pending;
  logic [1:0]    stateDbg;
`ifdef LOAD_ADDR_EXC_EN
  logic          adel;
`endif

  int nChecks = 0;
  int nErrors = 0;

  // {adel, dest, data}
  logic [37:0] exp_q[$];

  load_align_wb #(.DEST_W(DW), .RT_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .addr_low2(addr_low2), .rt_old(rt_old), .dest(dest),
    .sram_rdata(sram_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_data(wb_data), .wb_dest(wb_dest),
    .load_pending(load_pending), .pending_dest(pending_dest),
`ifdef LOAD_ADDR_EXC_EN
    .adel(adel),
`endif
    .stateDbg(stateDbg)
  );

  // Clock
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference formatter written from the byte-lane rules with arithmetic
  function automatic logic [31:0] refFormat(input logic [2:0] size, input logic sx,
                                            input logic [1:0] off, input logic [31:0] rt,
                                            input logic [31:0] m);
    logic [31:0] v;
    int sh;
    v = 32'h0;
    case (size)
      3'd0: begin
        v = (m >> (off * 8)) & 32'hFF;
        if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      3'd1: begin
        v = (m >> (off[1] * 16)) & 32'hFFFF;
        if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      3'd2: v = m;
      3'd3: begin
        sh = 8 * (3 - off);
        v = (m << sh) | (rt & ((32'h1 << sh) - 32'h1));
      end
      3'd4: begin
        sh = 8 * off;
        v = (m >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
      end
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic refAdel(input logic [2:0] size, input logic [1:0] off);
`ifdef LOAD_ADDR_EXC_EN
    return (size == 3'd1 && off[0]) || (size == 3'd2 && off != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [37:0] refResult(input logic [2:0] size, input logic sx,
                                            input logic [1:0] off, input logic [31:0] rt,
                                            input logic [31:0] m, input logic [DW-1:0] d);
    logic a;
    a = refAdel(size, off);
    return {a, d, (a ? 32'h0 : refFormat(size, sx, off, rt, m))};
  endfunction

  task automatic driveIdle();
    in_valid = 0; mode = 6'h0; addr_low2 = 0; rt_old = 0; dest = 0;
    sram_rdata = 32'h0; out_ready = 1;
  endtask

  task automatic driveLoad(input logic [2:0] size, input logic sx, input logic [1:0] off,
                           input logic [31:0] rt, input logic [DW-1:0] d);
    in_valid = 1; mode = {1'b1, 1'b0, size, sx}; addr_low2 = off; rt_old = rt; dest = d;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  size;
    logic        sx;
    logic [1:0]  off;
    logic [31:0] rt;
    logic [31:0] m;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] pendRdata;
    bit          lastAcc;
    bit          expReady;

    vecs[0]  = '{"lb_sign",   3'd0, 1'b1, 2'd2, 32'h0,         32'h1285_3456, 32'hFFFF_FF85};
    vecs[1]  = '{"lbu",       3'd0, 1'b0, 2'd2, 32'h0,         32'h1285_3456, 32'h0000_0085};
    vecs[2]  = '{"lwl_off1",  3'd3, 1'b0, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD};
    vecs[3]  = '{"lwr_off1",  3'd4, 1'b0, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'hAA11_2233};
    vecs[4]  = '{"lh_sign",   3'd1, 1'b1, 2'd2, 32'h0,         32'h8001_0000, 32'hFFFF_8001};
    vecs[5]  = '{"lhu_off2",  3'd1, 1'b0, 2'd2, 32'h0,         32'h8001_0000, 32'h0000_8001};
    vecs[6]  = '{"lw",        3'd2, 1'b1, 2'd0, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[7]  = '{"size101",   3'd5, 1'b1, 2'd0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{"lwl_off0",  3'd3, 1'b0, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD};
    vecs[9]  = '{"lwr_off3",  3'd4, 1'b0, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11};
    vecs[10] = '{"lb_pos",    3'd0, 1'b1, 2'd0, 32'h0,         32'h0000_007F, 32'h0000_007F};
    vecs[11] = '{"lwl_off3",  3'd3, 1'b0, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344};

    // Reset
    resetn = 0;
    driveIdle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    check("rst_wb_dest", 64'(wb_dest), 64'd0);
    check("rst_pending", 64'(load_pending), 64'd0);
    check("rst_pending_dest", 64'(pending_dest), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    resetn = 1;

    // Directed vector table: one load each, consumed immediately
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      driveLoad(vecs[i].size, vecs[i].sx, vecs[i].off, vecs[i].rt, DW'(i + 3));
      sram_rdata = $urandom();
      @(posedge clk); #1;
      in_valid = 0;
      sram_rdata = vecs[i].m;
      @(negedge clk);
      check({vecs[i].name, "_valid"}, 64'(out_valid), 64'd1);
      check({vecs[i].name, "_data"}, 64'(wb_data), 64'(vecs[i].exp));
      check({vecs[i].name, "_dest"}, 64'(wb_dest), 64'(i + 3));
      @(posedge clk); #1;
      sram_rdata = $urandom();
      @(negedge clk);
      check({vecs[i].name, "_drained"}, 64'(out_valid), 64'd0);
    end

    // Back-to-back LW then LH with out_ready held high
    @(posedge clk); #1;
    driveLoad(3'd2, 1'b0, 2'd0, 32'h0, 5'd7);
    out_ready = 1;
    @(posedge clk); #1;
    sram_rdata = 32'h1234_5678;
    driveLoad(3'd1, 1'b1, 2'd2, 32'h0, 5'd9);
    @(negedge clk);
    check("b2b_lw_valid", 64'(out_valid), 64'd1);
    check("b2b_lw_data", 64'(wb_data), 64'h1234_5678);
    check("b2b_lw_dest", 64'(wb_dest), 64'd7);
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 0;
    sram_rdata = 32'h8001_0000;
    @(negedge clk);
    check("b2b_lh_valid", 64'(out_valid), 64'd1);
    check("b2b_lh_data", 64'(wb_data), 64'hFFFF_8001);
    check("b2b_lh_dest", 64'(wb_dest), 64'd9);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_done", 64'(out_valid), 64'd0);

    // Stall: WB not ready for 3 cycles while SRAM data changes
    @(posedge clk); #1;
    driveLoad(3'd2, 1'b0, 2'd0, 32'h0, 5'd11);
    out_ready = 0;
    @(posedge clk); #1;
    sram_rdata = 32'hDEAD_BEEF;
    driveLoad(3'd0, 1'b0, 2'd1, 32'h0, 5'd12);
    @(negedge clk);
    check("stall_data_cycle", 64'(wb_data), 64'hDEAD_BEEF);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      sram_rdata = 32'h0;
      @(negedge clk);
      check("stall_state_held", 64'(stateDbg), 64'd2);
      check("stall_wb_data", 64'(wb_data), 64'hDEAD_BEEF);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_pending", 64'(load_pending), 64'd1);
      check("stall_pending_dest", 64'(pending_dest), 64'd11);
    end
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    check("stall_release_data", 64'(wb_data), 64'hDEAD_BEEF);
    check("stall_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_consumed", 64'(out_valid), 64'd0);

    // Non-load request is ignored
    @(posedge clk); #1;
    in_valid = 1; mode = 6'b010100;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("nonload_ignored", 64'(out_valid), 64'd0);

    // Reset while HELD
    @(posedge clk); #1;
    driveLoad(3'd2, 1'b0, 2'd0, 32'h0, 5'd20);
    out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    sram_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_held", 64'(stateDbg), 64'd2);
    @(posedge clk); #1;
    resetn = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_held_valid", 64'(out_valid), 64'd0);
    check("rst_held_data", 64'(wb_data), 64'd0);
    check("rst_held_pending", 64'(load_pending), 64'd0);
    check("rst_held_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    resetn = 1;
    out_ready = 1;

`ifdef LOAD_ADDR_EXC_EN
    // Misaligned word raises adel and zeroes data; aligned halfword does not
    @(posedge clk); #1;
    driveLoad(3'd2, 1'b0, 2'd2, 32'h0, 5'd4);
    @(posedge clk); #1;
    sram_rdata = 32'h1234_5678;
    driveLoad(3'd1, 1'b0, 2'd2, 32'h0, 5'd5);
    @(negedge clk);
    check("adel_lw_off2", 64'(adel), 64'd1);
    check("adel_lw_data", 64'(wb_data), 64'd0);
    check("adel_lw_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    in_valid = 0;
    sram_rdata = 32'h8001_0000;
    @(negedge clk);
    check("adel_lh_off2", 64'(adel), 64'd0);
    check("adel_lh_data", 64'(wb_data), 64'h0000_8001);
    @(posedge clk); #1;
`endif

    // Randomized stream against the reference model
    exp_q.delete();
    lastAcc = 0;
    pendRdata = 32'h0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      sram_rdata = lastAcc ? pendRdata : $urandom();
      in_valid = ($urandom_range(0, 9) < 6);
      mode = {($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
      addr_low2 = 2'($urandom_range(0, 3));
      rt_old = $urandom();
      dest = DW'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      expReady = (exp_q.size() == 0) || out_ready;
      check("rnd_in_ready", 64'(in_ready), 64'(expReady));
      check("rnd_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("rnd_pending", 64'(load_pending), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("rnd_wb_data", 64'(wb_data), 64'(exp_q[0][31:0]));
        check("rnd_wb_dest", 64'(wb_dest), 64'(exp_q[0][36:32]));
        check("rnd_pending_dest", 64'(pending_dest), 64'(exp_q[0][36:32]));
`ifdef LOAD_ADDR_EXC_EN
        check("rnd_adel", 64'(adel), 64'(exp_q[0][37]));
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
      lastAcc = in_valid && mode[5] && expReady;
      if (lastAcc) begin
        pendRdata = $urandom();
        exp_q.push_back(refResult(mode[3:1], mode[0], addr_low2, rt_old, pendRdata, dest));
      end
    end

    // Drain
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
    sram_rdata = lastAcc ? pendRdata : 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("final_drained", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
